// File: rtl/fpu_divider.sv
// Iterative IEEE-754 single-precision divider (a / b): restoring mantissa division,
// one quotient bit per cycle, truncating rounding, denormals flushed to zero.
module fpu_divider #(
   parameter int EXP_W  = 8,
   parameter int FRAC_W = 23,
   parameter int BIAS   = 127
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [EXP_W+FRAC_W:0]    a,
   input  logic [EXP_W+FRAC_W:0]    b,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+FRAC_W:0]    result,
   output logic                     flag_invalid,
   output logic                     flag_div_zero,
   output logic                     flag_overflow,
   output logic                     flag_underflow
);
   localparam int W  = 1 + EXP_W + FRAC_W;
   localparam int MW = FRAC_W + 2;          // quotient / remainder width
   localparam int EW = EXP_W + 2;           // signed exponent arithmetic width
   localparam int CW = $clog2(MW);
   localparam logic [EXP_W-1:0] EXP_MAX  = '1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(MW - 1);
   localparam logic [W-1:0]     QNAN     = {1'b0, EXP_MAX, 1'b1, {(FRAC_W-1){1'b0}}};

   typedef enum logic [1:0] {IDLE, DIVIDE, NORM, HOLD} state_t;
   state_t state, state_nxt;

   logic               sa, sb;
   logic [EXP_W-1:0]   ea_in, eb_in;
   logic [FRAC_W-1:0]  fa_in, fb_in;
   logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic               accept;

   logic               spec_hit, spec_inv, spec_dz;
   logic [W-1:0]       spec_res;

   logic               sign_q;
   logic [EXP_W-1:0]   ea_q, eb_q;
   logic [FRAC_W:0]    mb_q;
   logic [MW-1:0]      rem_q, quo_q, rem_sub, rem_sel;
   logic [CW-1:0]      cnt_q;
   logic               rem_ge;

   logic [EW-1:0]      e_norm;
   logic [FRAC_W-1:0]  mant;
   logic               e_ovf, e_unf;

   assign {sa, ea_in, fa_in} = a;
   assign {sb, eb_in, fb_in} = b;
   assign a_zero = (ea_in == '0);
   assign b_zero = (eb_in == '0);
   assign a_inf  = (ea_in == EXP_MAX) && (fa_in == '0);
   assign b_inf  = (eb_in == EXP_MAX) && (fb_in == '0);
   assign a_nan  = (ea_in == EXP_MAX) && (fa_in != '0);
   assign b_nan  = (eb_in == EXP_MAX) && (fb_in != '0);
   assign accept = in_valid && (state == IDLE);

   // NOTE: every signal written in always_comb gets a default first, so no path infers a latch.
   always_comb begin
      spec_hit = 1'b1;
      spec_inv = 1'b0;
      spec_dz  = 1'b0;
      spec_res = '0;
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res = QNAN;
         spec_inv = 1'b1;
      end else if (a_inf) begin
         spec_res = {sa ^ sb, EXP_MAX, {FRAC_W{1'b0}}};
      end else if (b_zero) begin
         spec_res = {sa ^ sb, EXP_MAX, {FRAC_W{1'b0}}};
         spec_dz  = 1'b1;
      end else if (a_zero || b_inf) begin
         spec_res = {sa ^ sb, {(W-1){1'b0}}};
      end else begin
         spec_hit = 1'b0;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)       state_nxt = spec_hit ? HOLD : DIVIDE;
         DIVIDE:  if (cnt_q == '0)    state_nxt = NORM;
         NORM:                        state_nxt = HOLD;
         HOLD:    if (out_ready)      state_nxt = IDLE;
         default:                     state_nxt = IDLE;
      endcase
   end

   always_comb begin
      in_ready  = (state == IDLE);
      out_valid = (state == HOLD);
   end

   // Remainder is always below 2*mb, so the shifted value fits without its top bit.
   assign rem_ge  = (rem_q >= MW'(mb_q));
   assign rem_sub = rem_q - MW'(mb_q);
   assign rem_sel = rem_ge ? rem_sub : rem_q;

   // NOTE: the datapath holds no reset; its contents only matter after an accept loads it.
   always_ff @(posedge clk) begin
      if (accept) begin
         sign_q <= sa ^ sb;
         ea_q   <= ea_in;
         eb_q   <= eb_in;
         mb_q   <= {1'b1, fb_in};
         rem_q  <= MW'({1'b1, fa_in});
         quo_q  <= '0;
         cnt_q  <= CNT_LAST;
      end else if (state == DIVIDE) begin
         quo_q  <= {quo_q[MW-2:0], rem_ge};
         rem_q  <= {rem_sel[MW-2:0], 1'b0};
         cnt_q  <= cnt_q - CW'(1);
      end
   end

   assign e_norm = EW'(ea_q) - EW'(eb_q) + (quo_q[MW-1] ? EW'(BIAS) : EW'(BIAS - 1));
   assign mant   = quo_q[MW-1] ? quo_q[FRAC_W:1] : quo_q[FRAC_W-1:0];
   assign e_unf  = e_norm[EW-1] || (e_norm == '0);
   assign e_ovf  = !e_norm[EW-1] && (e_norm >= EW'(EXP_MAX));

   always_ff @(posedge clk) begin
      if (rst) begin
         result         <= '0;
         flag_invalid   <= 1'b0;
         flag_div_zero  <= 1'b0;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
      end else if (accept) begin
         result         <= spec_res;
         flag_invalid   <= spec_inv;
         flag_div_zero  <= spec_dz;
         flag_overflow  <= 1'b0;
         flag_underflow <= 1'b0;
      end else if (state == NORM) begin
         flag_overflow  <= e_ovf;
         flag_underflow <= e_unf;
         if (e_ovf)      result <= {sign_q, EXP_MAX, {FRAC_W{1'b0}}};
         else if (e_unf) result <= {sign_q, {(W-1){1'b0}}};
         else            result <= {sign_q, e_norm[EXP_W-1:0], mant};
      end
   end

endmodule

// File: tb/tb_fpu_divider.sv
// Self-checking bench for fpu_divider: vector table with a scoreboard queue, plus
// hand-written backpressure and mid-operation reset sequences.
module tb_fpu_divider;
   logic        clk = 1'b0;
   logic        rst, in_valid, out_ready;
   logic        in_ready, out_valid;
   logic [31:0] a, b, result;
   logic        flag_invalid, flag_div_zero, flag_overflow, flag_underflow;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string       name;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] res;
      logic [3:0]  flags;   // {invalid, div_zero, overflow, underflow}
      int          lat;
   } vec_t;

   typedef struct {
      logic [31:0] res;
      logic [3:0]  flags;
   } exp_t;

   vec_t vecs[$];
   exp_t sb_q[$];

   fpu_divider dut (
      .clk            (clk),
      .rst            (rst),
      .in_valid       (in_valid),
      .in_ready       (in_ready),
      .a              (a),
      .b              (b),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .result         (result),
      .flag_invalid   (flag_invalid),
      .flag_div_zero  (flag_div_zero),
      .flag_overflow  (flag_overflow),
      .flag_underflow (flag_underflow)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   function automatic logic [3:0] flags_now();
      return {flag_invalid, flag_div_zero, flag_overflow, flag_underflow};
   endfunction

   // Drive one operation, measure latency, compare against the scoreboard, then consume.
   task automatic run_vec(input vec_t v);
      int   edges;
      exp_t e;
      edges = 0;
      while (!in_ready && edges < 64) begin
         @(negedge clk);
         edges++;
      end
      check({v.name, " in_ready"}, 32'(in_ready), 32'd1);
      a = v.a;
      b = v.b;
      in_valid = 1'b1;
      e.res   = v.res;
      e.flags = v.flags;
      sb_q.push_back(e);
      edges = 0;
      while (edges == 0 || (!out_valid && edges < 64)) begin
         @(negedge clk);
         in_valid = 1'b0;
         edges++;
      end
      check({v.name, " out_valid"}, 32'(out_valid), 32'd1);
      if (out_valid) begin
         check({v.name, " latency"}, 32'(edges), 32'(v.lat));
         if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check({v.name, " result"}, result, e.res);
            check({v.name, " flags"}, 32'(flags_now()), 32'(e.flags));
         end else begin
            check({v.name, " scoreboard empty"}, 32'd0, 32'd1);
         end
      end
      out_ready = 1'b1;
      @(negedge clk);
      check({v.name, " drop out_valid"}, 32'(out_valid), 32'd0);
   endtask

   initial begin
      int   edges;
      int   seen;
      exp_t e;

      vecs.push_back('{"6/2",       32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000, 27});
      vecs.push_back('{"1/3",       32'h3F800000, 32'h40400000, 32'h3EAAAAAA, 4'b0000, 27});
      vecs.push_back('{"-1/0",      32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0100, 1});
      vecs.push_back('{"0/0",       32'h00000000, 32'h00000000, 32'h7FC00000, 4'b1000, 1});
      vecs.push_back('{"ovf",       32'h7F000000, 32'h3E800000, 32'h7F800000, 4'b0010, 27});
      vecs.push_back('{"unf",       32'h00800000, 32'h40000000, 32'h00000000, 4'b0001, 27});
      vecs.push_back('{"nan/1",     32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b1000, 1});
      vecs.push_back('{"inf/-inf",  32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'b1000, 1});
      vecs.push_back('{"-inf/2",    32'hFF800000, 32'h40000000, 32'hFF800000, 4'b0000, 1});
      vecs.push_back('{"2/-inf",    32'h40000000, 32'hFF800000, 32'h80000000, 4'b0000, 1});
      vecs.push_back('{"-0/2",      32'h80000000, 32'h40000000, 32'h80000000, 4'b0000, 1});
      vecs.push_back('{"denorm/1",  32'h00000001, 32'h3F800000, 32'h00000000, 4'b0000, 1});
      vecs.push_back('{"2/denorm",  32'h40000000, 32'h00000001, 32'h7F800000, 4'b0100, 1});
      vecs.push_back('{"1/1",       32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000, 27});
      vecs.push_back('{"-7.5/2.5",  32'hC0F00000, 32'h40200000, 32'hC0400000, 4'b0000, 27});
      vecs.push_back('{"max/1",     32'h7F7FFFFF, 32'h3F800000, 32'h7F7FFFFF, 4'b0000, 27});
      vecs.push_back('{"min/1",     32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000, 27});

      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      a         = '0;
      b         = '0;
      repeat (2) @(negedge clk);
      check("reset in_ready",  32'(in_ready),    32'd1);
      check("reset out_valid", 32'(out_valid),   32'd0);
      check("reset result",    result,           32'd0);
      check("reset flags",     32'(flags_now()), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) run_vec(vecs[i]);

      // Backpressure: result held while new operands wait on in_valid.
      out_ready = 1'b0;
      a = 32'h40C00000;
      b = 32'h40000000;
      in_valid = 1'b1;
      e.res   = 32'h40400000;
      e.flags = 4'b0000;
      sb_q.push_back(e);
      edges = 0;
      while (edges == 0 || (!out_valid && edges < 64)) begin
         @(negedge clk);
         in_valid = 1'b0;
         edges++;
      end
      check("bp out_valid", 32'(out_valid), 32'd1);
      check("bp latency",   32'(edges),     32'd27);
      e = sb_q.pop_front();
      check("bp result", result, e.res);
      a = 32'h3F800000;
      b = 32'h40400000;
      in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check($sformatf("bp hold%0d result", i),    result,          e.res);
         check($sformatf("bp hold%0d in_ready", i),  32'(in_ready),   32'd0);
         check($sformatf("bp hold%0d out_valid", i), 32'(out_valid),  32'd1);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release in_ready",  32'(in_ready),  32'd1);
      check("bp release out_valid", 32'(out_valid), 32'd0);

      // Reset in the middle of DIVIDE discards the operation.
      a = 32'h40C00000;
      b = 32'h40000000;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("mid in_ready busy", 32'(in_ready), 32'd0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid rst in_ready",  32'(in_ready),  32'd1);
      check("mid rst out_valid", 32'(out_valid), 32'd0);
      check("mid rst result",    result,         32'd0);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid rst no output", 32'(seen), 32'd0);
      run_vec(vecs[0]);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/fpu_divider.md
Name: fpu_divider

Overview:
- Iterative IEEE-754 single-precision divider: result = a / b.
- Companion to the combinational FP multiplier. Sits beside it in the FPU datapath and shares the same 32-bit operand format (1 sign, 8 exponent, 23 fraction, bias 127).
- Sequential restoring mantissa division, one quotient bit per cycle, with a valid/ready handshake on both sides.
- Rounding: truncation (toward zero). Denormals are flushed to zero.

Parameters:
- EXP_W, 8, exponent width
- FRAC_W, 23, stored fraction width (hidden bit added internally)
- BIAS, 127, exponent bias

Ports:
- clk  input  1  single clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands a/b presented
- in_ready  output  1  divider idle and able to accept
- a  input  32  dividend
- b  input  32  divisor
- out_valid  output  1  result and flags valid, held until consumed
- out_ready  input  1  consumer accepts result
- result  output  32  quotient
- flag_invalid  output  1  NaN operand, 0/0, or inf/inf
- flag_div_zero  output  1  finite nonzero / zero
- flag_overflow  output  1  exponent overflow, result forced to inf
- flag_underflow  output  1  exponent underflow, result flushed to zero

Behaviour:
- Reset (rst=1 at an edge):
  - Outputs: in_ready=1, out_valid=0, result=0, all flags=0.
  - FSM goes to IDLE. Any in-flight division is discarded with no output.
- FSM states: IDLE, DIVIDE, NORM, HOLD.
- IDLE:
  - in_ready=1. Accept on an edge with in_valid=1; a and b are latched.
  - If the operand pair is a special case, go straight to HOLD (out_valid=1 after 1 edge). Otherwise go to DIVIDE.
- Special cases (exp=0 is treated as zero; sign = sa^sb unless the result is NaN):
  - Any NaN, 0/0, or inf/inf -> 0x7FC00000, flag_invalid=1.
  - inf/finite -> signed inf.
  - Nonzero finite/0 -> signed inf, flag_div_zero=1.
  - 0/nonzero, or finite/inf -> signed zero.
- DIVIDE (25 cycles, counter 24 down to 0):
  - Setup: ma={1,fa}, mb={1,fb}, remainder r=ma (25 bits).
  - Each cycle: if r>=mb then q[i]=1 and r=r-mb; then r=r<<1.
  - Result: q = floor(ma*2^24/mb), 25 bits, q in [2^23, 2^25).
- NORM (1 cycle; exponent arithmetic signed, 10 bits wide):
  - If q[24]=1: mant=q[23:1], e=ea-eb+127.
  - Else: mant=q[22:0], e=ea-eb+126.
  - e>=255 -> signed inf, flag_overflow=1.
  - e<=0 -> signed zero, flag_underflow=1.
  - Otherwise result = {sa^sb, e[7:0], mant}.
  - Go to HOLD.
- HOLD:
  - out_valid=1; result and flags stable.
  - in_ready=0; in_valid is ignored.
  - An edge with out_ready=1 returns to IDLE; out_valid drops the next cycle.
  - The next operand can be accepted no earlier than the cycle after the result is consumed (no overlap).
- Latency, counted from the accept edge:
  - Normal operands: out_valid=1 after exactly 27 edges (25 DIVIDE + 1 NORM + 1 entry).
  - Special cases: out_valid=1 after 1 edge.
  - Throughput is one operation per 28 cycles minimum.
- Flags are valid only while out_valid=1. They are cleared on accept of new operands.
- in_valid during DIVIDE or NORM has no effect. Operands must be re-presented once in_ready=1.

Test Plan:
- a=0x40C00000 (6.0), b=0x40000000 (2.0), out_ready=1 -> result=0x40400000, all flags 0, out_valid exactly 27 edges after accept.
- a=0x3F800000, b=0x40400000 (1/3) -> result=0x3EAAAAAA (truncated, not 0x3EAAAAAB).
- a=0xBF800000, b=0x00000000 -> result=0xFF800000, flag_div_zero=1, 1-cycle latency. Then a=0, b=0 -> 0x7FC00000, flag_invalid=1.
- Overflow/underflow:
  - a=0x7F000000, b=0x3E800000 -> 0x7F800000, flag_overflow=1.
  - a=0x00800000, b=0x40000000 -> 0x00000000, flag_underflow=1.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid, with in_valid=1 and new operands present -> result stable, in_ready=0, new operands not taken. Release out_ready -> in_ready=1 the next cycle.
- Reset mid-operation: assert rst at DIVIDE cycle 10 -> next cycle in_ready=1, out_valid=0, result=0. A following 6.0/2.0 divide completes correctly.
